// File: rtl/mult_booth_seq.sv
// mult_booth_seq: iterative signed N x N multiplier using radix-2 or radix-4
// Booth recoding over an {A, Q, Q-1} shift register, with start/busy/done
// handshake. producto is registered and only changes on completion or reset.
module mult_booth_seq #(
  parameter int N      = 8,
  parameter bit RADIX4 = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic [2*N-1:0] producto,
  output logic           busy,
  output logic           done
);

  localparam int K  = RADIX4 ? (N / 2) : N;
  localparam int CW = $clog2(K + 1);
  localparam int AW = N + 2;
  localparam logic [CW-1:0] LAST_STEP = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [N-1:0]    q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [N-1:0]    m_q, m_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2*N-1:0]  prod_q, prod_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [AW-1:0]   m_ext_s;
  logic [AW-1:0]   m2_ext_s;
  logic [AW-1:0]   addend_s;
  logic            sub_s;
  logic [AW-1:0]   sum_s;
  logic [AW-1:0]   a_step_s;
  logic [N-1:0]    q_step_s;
  logic            qm1_step_s;

  // One Booth step: recode the low multiplier bits, add/subtract M or 2M on
  // N+2 bits (wide enough for 2*(-2^(N-1))), then arithmetic-shift {A,Q,Q-1}.
  always_comb begin
    m_ext_s  = {{2{m_q[N-1]}}, m_q};
    m2_ext_s = {m_ext_s[AW-2:0], 1'b0};
    addend_s = {AW{1'b0}};
    sub_s    = 1'b0;
    if (RADIX4) begin
      case ({q_q[1:0], qm1_q})
        3'b001, 3'b010: begin addend_s = m_ext_s;  sub_s = 1'b0; end
        3'b011:         begin addend_s = m2_ext_s; sub_s = 1'b0; end
        3'b100:         begin addend_s = m2_ext_s; sub_s = 1'b1; end
        3'b101, 3'b110: begin addend_s = m_ext_s;  sub_s = 1'b1; end
        default:        begin addend_s = {AW{1'b0}}; sub_s = 1'b0; end
      endcase
    end else begin
      case ({q_q[0], qm1_q})
        2'b01:   begin addend_s = m_ext_s; sub_s = 1'b0; end
        2'b10:   begin addend_s = m_ext_s; sub_s = 1'b1; end
        default: begin addend_s = {AW{1'b0}}; sub_s = 1'b0; end
      endcase
    end
    if (sub_s) begin
      sum_s = a_q - addend_s;
    end else begin
      sum_s = a_q + addend_s;
    end
    if (RADIX4) begin
      a_step_s   = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
      q_step_s   = {sum_s[1:0], q_q[N-1:2]};
      qm1_step_s = q_q[1];
    end else begin
      a_step_s   = {sum_s[AW-1], sum_s[AW-1:1]};
      q_step_s   = {sum_s[0], q_q[N-1:1]};
      qm1_step_s = q_q[0];
    end
  end

  // Control sequencing: accept in IDLE, iterate K steps in CALC, pulse DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    count_d = count_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          a_d     = {AW{1'b0}};
          q_d     = multiplicador;
          qm1_d   = 1'b0;
          m_d     = multiplicando;
          count_d = {CW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      CALC: begin
        a_d     = a_step_s;
        q_d     = q_step_s;
        qm1_d   = qm1_step_s;
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          prod_d  = {a_step_s[N-1:0], q_step_s};
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any partial run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= {AW{1'b0}};
      q_q     <= {N{1'b0}};
      qm1_q   <= 1'b0;
      m_q     <= {N{1'b0}};
      count_q <= {CW{1'b0}};
      prod_q  <= {(2*N){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      count_q <= count_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign producto = prod_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq: an N=4 radix-2 instance and an N=8
// radix-4 instance share clock and reset. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_mult_booth_seq;

  logic        clk;
  logic        reset;
  logic        start4, busy4, done4;
  logic [3:0]  mc4, mp4;
  logic [7:0]  prod4;
  logic        start8, busy8, done8;
  logic [7:0]  mc8, mp8;
  logic [15:0] prod8;

  int pass_cnt;
  int total_cnt;

  mult_booth_seq #(.N(4), .RADIX4(1'b0)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .multiplicando(mc4), .multiplicador(mp4),
    .producto(prod4), .busy(busy4), .done(done4)
  );

  mult_booth_seq #(.N(8), .RADIX4(1'b1)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .multiplicando(mc8), .multiplicador(mp8),
    .producto(prod8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one N=4 operation from a falling edge; returns product, latency in
  // edges after acceptance, busy cycle count, and done one cycle later.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] p, output int lat, output int bcnt,
                      output logic dn_after);
    mc4 = a; mp4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0; bcnt = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      if (busy4 === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    p = prod4;
    @(negedge clk);
    dn_after = done4;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat, output int bcnt,
                      output logic dn_after);
    mc8 = a; mp8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      if (busy8 === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    p = prod8;
    @(negedge clk);
    dn_after = done8;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    mc4 = 4'h0; mp4 = 4'h0; mc8 = 8'h00; mp8 = 8'h00;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy4, done4, prod4} !== 10'b0) $display("FAIL reset4: busy=%b done=%b prod=%h, expected 0/0/00", busy4, done4, prod4);
    else pass_cnt++;
    total_cnt++;
    if ({busy8, done8, prod8} !== 18'b0) $display("FAIL reset8: busy=%b done=%b prod=%h, expected 0/0/0000", busy8, done8, prod8);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_r2_basic();
    logic [7:0] p; int lat; int bcnt; logic dn;
    run4(4'h3, 4'hE, p, lat, bcnt, dn);
    total_cnt++;
    if (p !== 8'hFA) $display("FAIL r2_3x-2: got %h expected FA", p); else pass_cnt++;
    total_cnt++;
    if (lat != 4) $display("FAIL r2_latency: got %0d expected 4", lat); else pass_cnt++;
    total_cnt++;
    if (bcnt != 4) $display("FAIL r2_busy_cycles: got %0d expected 4", bcnt); else pass_cnt++;
    total_cnt++;
    if (dn !== 1'b0) $display("FAIL r2_done_pulse: done=%b one cycle later, expected 0", dn); else pass_cnt++;
    run4(4'h8, 4'h8, p, lat, bcnt, dn);
    total_cnt++;
    if (p !== 8'h40) $display("FAIL r2_-8x-8: got %h expected 40", p); else pass_cnt++;
    run4(4'h7, 4'h8, p, lat, bcnt, dn);
    total_cnt++;
    if (p !== 8'hC8) $display("FAIL r2_7x-8: got %h expected C8", p); else pass_cnt++;
  endtask

  task automatic test_r2_exhaustive();
    logic [7:0] p; int lat; int bcnt; logic dn;
    logic signed [3:0] a, b;
    logic signed [7:0] e;
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        a = 4'(i); b = 4'(j);
        e = a * b;
        run4(a, b, p, lat, bcnt, dn);
        total_cnt++;
        if (p !== e || lat != 4) $display("FAIL r2_sweep %0d*%0d: got %h lat %0d expected %h lat 4", i, j, p, lat, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_r4_corners();
    logic [15:0] p; int lat; int bcnt; logic dn;
    run8(8'h80, 8'h80, p, lat, bcnt, dn);
    total_cnt++;
    if (p !== 16'h4000) $display("FAIL r4_-128x-128: got %h expected 4000", p); else pass_cnt++;
    total_cnt++;
    if (lat != 4 || bcnt != 4) $display("FAIL r4_timing: lat %0d busy %0d expected 4/4", lat, bcnt); else pass_cnt++;
    total_cnt++;
    if (dn !== 1'b0) $display("FAIL r4_done_pulse: done=%b one cycle later, expected 0", dn); else pass_cnt++;
    run8(8'h7F, 8'h80, p, lat, bcnt, dn);
    total_cnt++;
    if (p !== 16'hC080) $display("FAIL r4_127x-128: got %h expected C080", p); else pass_cnt++;
    run8(8'hFF, 8'h01, p, lat, bcnt, dn);
    total_cnt++;
    if (p !== 16'hFFFF) $display("FAIL r4_-1x1: got %h expected FFFF", p); else pass_cnt++;
    run8(8'h00, 8'h9C, p, lat, bcnt, dn);
    total_cnt++;
    if (p !== 16'h0000) $display("FAIL r4_0x-100: got %h expected 0000", p); else pass_cnt++;
  endtask

  task automatic test_r4_sweep();
    logic [15:0] p; int lat; int bcnt; logic dn;
    logic signed [7:0] vals [10];
    logic signed [15:0] e;
    vals = '{8'sh80, 8'sh81, 8'shC0, 8'shFD, 8'shFF, 8'sh00, 8'sh01, 8'sh02, 8'sh55, 8'sh7F};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        e = vals[i] * vals[j];
        run8(vals[i], vals[j], p, lat, bcnt, dn);
        total_cnt++;
        if (p !== e || lat != 4) $display("FAIL r4_sweep %0d*%0d: got %h lat %0d expected %h lat 4", vals[i], vals[j], p, lat, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_ignore_start();
    int n; int dcnt;
    mc8 = 8'h19; mp8 = 8'hFD; start8 = 1'b1;
    @(negedge clk);
    mc8 = 8'h63; mp8 = 8'h63;
    n = 0; dcnt = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done8 === 1'b1) dcnt++;
    total_cnt++;
    if (prod8 !== 16'hFFB5 || n != 4) $display("FAIL ign_midrun: got %h lat %0d expected FFB5 lat 4", prod8, n); else pass_cnt++;
    mc8 = 8'h06; mp8 = 8'h07;
    @(negedge clk);
    if (done8 === 1'b1) dcnt++;
    total_cnt++;
    if (dcnt != 1) $display("FAIL ign_one_done: got %0d pulses expected 1", dcnt); else pass_cnt++;
    total_cnt++;
    if (busy8 !== 1'b0) $display("FAIL ign_start_at_done: busy=%b expected 0", busy8); else pass_cnt++;
    total_cnt++;
    if (prod8 !== 16'hFFB5) $display("FAIL ign_hold: got %h expected FFB5", prod8); else pass_cnt++;
    @(negedge clk);
    start8 = 1'b0;
    total_cnt++;
    if (busy8 !== 1'b1) $display("FAIL ign_next_accept: busy=%b expected 1", busy8); else pass_cnt++;
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (prod8 !== 16'h002A || n != 4) $display("FAIL ign_6x7: got %h lat %0d expected 002A lat 4", prod8, n); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] p; int lat; int bcnt; logic dn; int dcnt;
    mc8 = 8'h64; mp8 = 8'h64; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({busy8, done8, prod8} !== 18'b0) $display("FAIL rst_mid: busy=%b done=%b prod=%h expected 0/0/0000", busy8, done8, prod8);
    else pass_cnt++;
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) dcnt++;
    end
    total_cnt++;
    if (dcnt != 0) $display("FAIL rst_no_done: got %0d active cycles expected 0", dcnt); else pass_cnt++;
    run8(8'h05, 8'h07, p, lat, bcnt, dn);
    total_cnt++;
    if (p !== 16'h0023) $display("FAIL rst_then_5x7: got %h expected 0023", p); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ta [6];
    logic [7:0]  tb [6];
    logic [15:0] te [6];
    ta = '{8'h80, 8'hB3, 8'h64, 8'hFF, 8'h40, 8'hCE};
    tb = '{8'h7F, 8'h2D, 8'h9C, 8'hFF, 8'h40, 8'hCD};
    te = '{16'hC080, 16'hF277, 16'hD8F0, 16'h0001, 16'h1000, 16'h09F6};
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      mc8 = ta[j]; mp8 = tb[j]; start8 = 1'b1;
      for (int n = 0; n <= 4; n++) begin
        @(negedge clk);
        if (n == 3) begin
          total_cnt++;
          if (done8 !== 1'b0) $display("FAIL b2b_early_done[%0d]: done=%b expected 0", j, done8); else pass_cnt++;
        end
      end
      total_cnt++;
      if (done8 !== 1'b1 || prod8 !== te[j]) $display("FAIL b2b_result[%0d]: done=%b prod=%h expected 1/%h", j, done8, prod8, te[j]);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done8 !== 1'b0 || prod8 !== te[j]) $display("FAIL b2b_hold[%0d]: done=%b prod=%h expected 0/%h", j, done8, prod8, te[j]);
      else pass_cnt++;
    end
    start8 = 1'b0;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (prod8 !== te[5] || busy8 !== 1'b0) $display("FAIL b2b_final_hold: prod=%h busy=%b expected %h/0", prod8, busy8, te[5]);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_r2_basic();
    test_r2_exhaustive();
    test_r4_corners();
    test_r4_sweep();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
